// File: rtl/intr_pkg.sv
// Shared types and defaults for the interrupt pending controller.
package intr_pkg;

  localparam int NUM_IRQ = 128;
  localparam int ID_W    = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Find-first-set over a vector: the lowest set index wins, with a valid flag.
module intr_prio_enc #(
  parameter int N = 128,
  parameter int W = 7
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_pending_ctrl.sv
// Edge-detecting interrupt pending controller with request/claim/complete handshake.
// Define INTR_SYNC_EN to add a two-flop synchronizer on the raw interrupt lines.
module intr_pending_ctrl
  import intr_pkg::*;
#(
  parameter int NUM_IRQ = intr_pkg::NUM_IRQ,
  parameter int ID_W    = intr_pkg::ID_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] test_input_intr_bundle,
  input  logic               intr_mask_we,
  input  logic [NUM_IRQ-1:0] intr_mask_wdata,
  output logic               intr_req,
  output logic [ID_W-1:0]    intr_id,
  input  logic               intr_ack,
  input  logic               intr_done,
  output logic [NUM_IRQ-1:0] intr_pending
);

  state_e              r_state, w_state_nxt;
  logic [NUM_IRQ-1:0]  w_lines, w_rise, w_clr;
  logic [NUM_IRQ-1:0]  r_prev, r_pending, r_mask;
  logic [ID_W-1:0]     r_id, w_win_id;
  logic                w_win_valid, w_claim;

`ifdef INTR_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= test_input_intr_bundle;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lines = r_sync2;
`else
  assign w_lines = test_input_intr_bundle;
`endif

  assign w_rise  = w_lines & ~r_prev;
  assign w_claim = (r_state == ST_REQ) && intr_ack;
  assign w_clr   = w_claim ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << r_id) : '0;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // A rise on the bit being claimed wins over the clear, keeping it pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_mask    <= '1;
    end else begin
      r_prev    <= w_lines;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (intr_mask_we) r_mask <= intr_mask_wdata;
    end
  end

  intr_prio_enc #(
    .N (NUM_IRQ),
    .W (ID_W)
  ) u_prio_enc (
    .i_vec   (r_pending & r_mask),
    .o_idx   (w_win_id),
    .o_valid (w_win_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_win_valid) r_id <= w_win_id;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_win_valid) w_state_nxt = ST_REQ;
      ST_REQ:    if (intr_ack)    w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (intr_done)   w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    intr_req = (r_state == ST_REQ);
  end

  assign intr_id      = r_id;
  assign intr_pending = r_pending;

endmodule

// File: tb/tb_intr_pending_ctrl.sv
// Scoreboard bench for intr_pending_ctrl; expected IDs are queued at stimulus time.
// Request latency expectation follows INTR_SYNC_EN.
module tb_intr_pending_ctrl;

  localparam int N = 128;
`ifdef INTR_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] lines;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic         intr_req;
  logic [6:0]   intr_id;
  logic         intr_ack;
  logic         intr_done;
  logic [N-1:0] intr_pending;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int n_req = 0;
  int n_p127 = 0;
  logic req_d = 1'b0;
  logic p127_d = 1'b0;

  intr_pending_ctrl dut (
    .clk                    (clk),
    .reset                  (reset),
    .test_input_intr_bundle (lines),
    .intr_mask_we           (mask_we),
    .intr_mask_wdata        (mask_wdata),
    .intr_req               (intr_req),
    .intr_id                (intr_id),
    .intr_ack               (intr_ack),
    .intr_done              (intr_done),
    .intr_pending           (intr_pending)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (intr_req && !req_d) n_req++;
    if (intr_pending[127] && !p127_d) n_p127++;
    req_d  = intr_req;
    p127_d = intr_pending[127];
  end

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req(output int cyc);
    cyc = 0;
    while (!intr_req && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!intr_req) check("req_timeout", 0, 1);
  endtask

  // Wait for a request, compare its ID with the scoreboard, claim it, then complete it.
  task automatic claim(input logic [N-1:0] ack_lines, input logic [N-1:0] exp_pend,
                       output int cyc);
    logic [N-1:0] saved;
    int exp_id;
    wait_req(cyc);
    if (exp_q.size() == 0) check("sb_unexpected_req", 1, 0);
    else begin
      exp_id = exp_q.pop_front();
      check("intr_id", N'(intr_id), N'(exp_id));
    end
    saved    = lines;
    lines    = ack_lines;
    intr_ack = 1'b1;
    @(negedge clk);
    intr_ack = 1'b0;
    lines    = saved;
    check("req_after_ack", N'(intr_req), 0);
    check("pend_after_ack", intr_pending, exp_pend);
    intr_done = 1'b1;
    @(negedge clk);
    intr_done = 1'b0;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    @(negedge clk);
    mask_we    = 1'b1;
    mask_wdata = m;
    @(negedge clk);
    mask_we    = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    @(negedge clk);
    lines = v;
    @(negedge clk);
    lines = '0;
  endtask

  initial begin
    int cyc;
    int n0, p0;
    logic [N-1:0] b127, b5, b9;
    b127 = '0; b127[127] = 1'b1;
    b5   = '0; b5[5]     = 1'b1;
    b9   = '0; b9[9]     = 1'b1;

    reset = 1'b1; lines = '0; mask_we = 1'b0; mask_wdata = '0;
    intr_ack = 1'b0; intr_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", N'(intr_req), 0);
    check("rst_id", N'(intr_id), 0);
    check("rst_pend", intr_pending, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Two sources at once: lowest first, then the other after completion.
    exp_q.push_back(1);
    exp_q.push_back(2);
    pulse(128'h6);
    claim('0, 128'h4, cyc);
    check("req_latency", N'(cyc + 1), N'(LAT));
    claim('0, 128'h0, cyc);
    check("idle_gap", N'(cyc), 1);

    // Masked source stays pending until re-enabled.
    write_mask(128'h4);
    exp_q.push_back(2);
    pulse(128'h6);
    claim('0, 128'h2, cyc);
    repeat (4) @(negedge clk);
    check("masked_no_req", N'(intr_req), 0);
    check("masked_pend", intr_pending, 128'h2);
    write_mask('1);
    exp_q.push_back(1);
    claim('0, 128'h0, cyc);

    // Level-high line raises exactly once.
    n0 = n_req; p0 = n_p127;
    @(negedge clk);
    lines = b127;
    exp_q.push_back(127);
    claim(b127, 128'h0, cyc);
    repeat (8) @(negedge clk);
    lines = '0;
    repeat (3) @(negedge clk);
    check("level_one_req", N'(n_req - n0), 1);
    check("level_one_pend", N'(n_p127 - p0), 1);
    check("level_pend_clear", intr_pending, 0);

    // Rise on the same cycle as the claim of that bit: set wins.
    exp_q.push_back(5);
    exp_q.push_back(5);
    pulse(b5);
    claim(b5, b5, cyc);
    claim('0, 128'h0, cyc);

    // Asynchronous reset while ACTIVE with another source pending.
    exp_q.push_back(2);
    pulse(128'hC);
    wait_req(cyc);
    check("rst_seq_id", N'(intr_id), N'(exp_q.pop_front()));
    intr_ack = 1'b1;
    @(negedge clk);
    intr_ack = 1'b0;
    check("active_pend", intr_pending, 128'h8);
    #2 reset = 1'b1;
    #1;
    check("async_rst_req", N'(intr_req), 0);
    check("async_rst_id", N'(intr_id), 0);
    check("async_rst_pend", intr_pending, 0);
    @(negedge clk);
    reset = 1'b0;
    n0 = n_req;
    repeat (10) @(negedge clk);
    check("post_rst_no_req", N'(n_req - n0), 0);
    check("post_rst_pend", intr_pending, 0);

    // A line high as reset releases counts as a rise.
    @(negedge clk);
    reset = 1'b1;
    lines = b9;
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(9);
    claim(b9, 128'h0, cyc);
    lines = '0;
    repeat (3) @(negedge clk);

    check("sb_drained", N'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/intr_pending_ctrl.md
# intr_pending_ctrl

- Receiving end of the core's `test_input_intr_bundle` interrupt lines.
- Edge-detects up to 128 interrupt sources and latches each into a pending bit.
- Masks the pending bits, selects the lowest-numbered enabled source, and presents it to the pipeline through a request/claim/complete handshake.
- Sits between the external interrupt bundle and the core's fast-interrupt entry logic in `top`.

## Interface
- `NUM_IRQ`, 128: number of interrupt sources.
- `ID_W`, 7: width of the interrupt ID; must equal clog2(`NUM_IRQ`).
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `test_input_intr_bundle` in `NUM_IRQ`: raw interrupt lines; a 0→1 transition raises the source.
- `intr_mask_we` in 1: write strobe for the enable mask.
- `intr_mask_wdata` in `NUM_IRQ`: new enable mask; bit i=1 enables source i.
- `intr_req` out 1: interrupt request to core.
- `intr_id` out `ID_W`: ID of the requested/active source.
- `intr_ack` in 1: core claims the request.
- `intr_done` in 1: core finished the handler (mret).
- `intr_pending` out `NUM_IRQ`: pending vector, for debug/CSR read.

## Operation
- Edge detect:
  - `prev` register holds the last sampled lines.
  - `rise = lines & ~prev`.
  - A `rise` bit sets the matching `pending` bit regardless of the mask.
- Mask register:
  - Reset value all-ones.
  - `intr_mask_we` loads `intr_mask_wdata` at the next edge.
  - Masking never clears pending bits.
- Priority: lowest index among `pending & mask` wins.
- FSM states:
  - IDLE: `intr_req`=0. If any enabled pending bit exists, register the winner into `intr_id` and go to REQ.
  - REQ: `intr_req`=1; `intr_id` held. On `intr_ack`, clear `pending[intr_id]`, drop `intr_req`, go to ACTIVE. Mask changes do not retract the request.
  - ACTIVE: `intr_req`=0; `intr_id` held. On `intr_done`, go to IDLE. No nesting.
- `intr_ack` outside REQ and `intr_done` outside ACTIVE are ignored.
- Simultaneous claim-clear and new rise on the same bit: the set wins, and the bit stays pending.
- Level-high lines produce one pending event only. They must fall and rise again to re-raise.
- Reset mid-operation:
  - FSM→IDLE; `pending`, `prev`, `intr_id` cleared; mask set to all-ones.
  - An in-flight claim is lost.
  - A line that is high when reset deasserts counts as a rise on the first cycle.

## Timing
- Reset values: `intr_req`=0, `intr_id`=0, `intr_pending`=0.
- Latency (without synchronizer):
  - Line sampled high at edge N: pending visible after N.
  - `intr_req`=1 after edge N+1.
- `intr_ack` sampled at edge M in REQ: `intr_req`=0 and `pending` bit clear after M. Next request no earlier than one cycle after `intr_done`.
- IDLE→REQ requires one full IDLE cycle after ACTIVE exits.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `INTR_SYNC_EN`:
  - Defined: two-flop synchronizer on `test_input_intr_bundle` ahead of edge detect; request latency becomes 4 cycles.
  - Undefined: lines are used directly, for a synchronous source (testbench, on-chip timers); latency is 2 cycles.

## Structure
- Package `intr_pkg`:
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, ACTIVE=2'd2).
  - `NUM_IRQ`/`ID_W` defaults.
- Sub-module `intr_prio_enc`: combinational find-first-set over `NUM_IRQ` bits. Outputs `ID_W` index plus a `valid` flag.

## Test plan
- Pulse `test_input_intr_bundle`=128'h6 for one cycle, ack/done each request:
  - `intr_req` rises 2 cycles later with `intr_id`=1.
  - After `intr_done`, a second request arrives with `intr_id`=2.
  - Pending ends at 0.
- Mask write 128'h4, then pulse 128'h6:
  - Only `intr_id`=2 is requested.
  - `intr_pending`=128'h2 remains.
  - Writing mask all-ones then yields request `intr_id`=1.
- Hold bit 127 high for 10 cycles: exactly one request with `intr_id`=127 and one pending event.
- Re-pulse bit 5 on the same cycle as `intr_ack` for `intr_id`=5: the bit stays pending and a second request for ID 5 follows after `intr_done`.
- Assert `reset` while in ACTIVE with bit 3 pending:
  - `intr_req`=0, `intr_id`=0, pending=0 immediately (asynchronous).
  - No request after deassert while lines are low.
- With `INTR_SYNC_EN` defined, pulse bit 0 for 1 cycle: `intr_req` rises 4 cycles after the pulse.
